// File: rtl/idu_pkg.sv
// Shared encodings for the decode stage: opcodes, legacy control-bundle codes and the
// packed control/system structs handed from IDU to EXU.
package idu_pkg;

  localparam logic [6:0] OpLoad    = 7'b0000011;
  localparam logic [6:0] OpMiscMem = 7'b0001111;
  localparam logic [6:0] OpImm     = 7'b0010011;
  localparam logic [6:0] OpAuipc   = 7'b0010111;
  localparam logic [6:0] OpStore   = 7'b0100011;
  localparam logic [6:0] OpReg     = 7'b0110011;
  localparam logic [6:0] OpLui     = 7'b0110111;
  localparam logic [6:0] OpBranch  = 7'b1100011;
  localparam logic [6:0] OpJalr    = 7'b1100111;
  localparam logic [6:0] OpJal     = 7'b1101111;
  localparam logic [6:0] OpSystem  = 7'b1110011;

  localparam logic [31:0] InstrEcall  = 32'h0000_0073;
  localparam logic [31:0] InstrEbreak = 32'h0010_0073;
  localparam logic [31:0] InstrMret   = 32'h3020_0073;

  typedef enum logic [2:0] {
    ExtI = 3'd0,
    ExtU = 3'd1,
    ExtS = 3'd2,
    ExtB = 3'd3,
    ExtJ = 3'd4
  } ext_op_e;

  // Unsigned compares reuse BrLt/BrGe; the ALU op (Sltu) carries signedness.
  typedef enum logic [2:0] {
    BrNone = 3'b000,
    BrJal  = 3'b001,
    BrJalr = 3'b010,
    BrEq   = 3'b100,
    BrNe   = 3'b101,
    BrLt   = 3'b110,
    BrGe   = 3'b111
  } branch_e;

  typedef enum logic [1:0] {
    AluBRs2  = 2'b00,
    AluBImm  = 2'b01,
    AluBFour = 2'b10
  } alu_b_e;

  typedef enum logic [3:0] {
    AluAdd   = 4'b0000,
    AluSll   = 4'b0001,
    AluSlt   = 4'b0010,
    AluCopyB = 4'b0011,
    AluXor   = 4'b0100,
    AluSrl   = 4'b0101,
    AluOr    = 4'b0110,
    AluAnd   = 4'b0111,
    AluSub   = 4'b1000,
    AluSltu  = 4'b1010,
    AluSra   = 4'b1101
  } alu_op_e;

  // MemOP mirrors load/store funct3.
  localparam logic [2:0] MemB  = 3'b000;
  localparam logic [2:0] MemH  = 3'b001;
  localparam logic [2:0] MemW  = 3'b010;
  localparam logic [2:0] MemD  = 3'b011;
  localparam logic [2:0] MemBu = 3'b100;
  localparam logic [2:0] MemHu = 3'b101;
  localparam logic [2:0] MemWu = 3'b110;

  // csr_op mirrors SYSTEM funct3.
  localparam logic [2:0] CsrNone = 3'b000;
  localparam logic [2:0] CsrRw   = 3'b001;
  localparam logic [2:0] CsrRs   = 3'b010;
  localparam logic [2:0] CsrRc   = 3'b011;
  localparam logic [2:0] CsrRwi  = 3'b101;
  localparam logic [2:0] CsrRsi  = 3'b110;
  localparam logic [2:0] CsrRci  = 3'b111;

  typedef struct packed {
    ext_op_e     ext_op;
    logic        reg_wr;
    branch_e     branch;
    logic        mem_to_reg;
    logic        mem_wr;
    logic [2:0]  mem_op;
    logic        mem_wen;
    logic        alu_a_ctr;
    alu_b_e      alu_b_ctr;
    alu_op_e     alu_ctr;
  } ctrl_t;

  typedef struct packed {
    logic [2:0]  csr_op;
    logic [11:0] csr_addr;
    logic        is_ecall;
    logic        is_ebreak;
    logic        is_mret;
    logic        is_fence;
    logic        illegal;
  } sys_t;

  // Base ALU op for OP/OP-IMM; sub and sra are selected by funct7 at the call site.
  function automatic alu_op_e alu_op_from_f3(input logic [2:0] f3);
    alu_op_e op;
    case (f3)
      3'b000:  op = AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/idu_decode_comb.sv
// Purely combinational RV32I (+ RV64 ld/lwu/sd, shamt[5]) decoder producing the control
// bundle, system decode, immediate and register indices for one instruction word.
module idu_decode_comb
  import idu_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter bit          ENABLE_CSR = 1'b1
) (
  input  logic [31:0]     instr,
  output ctrl_t           ctrl,
  output sys_t            sys,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd
);

  localparam bit Is64 = (XLEN == 64);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        illegal;
  logic        use_rd;
  logic        use_rs1;
  logic        use_rs2;
  logic        zimm_sel;
  logic [31:0] imm32;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    ctrl     = '0;
    sys      = '0;
    illegal  = 1'b0;
    use_rd   = 1'b0;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    zimm_sel = 1'b0;

    case (opcode)
      OpLui: begin
        ctrl.ext_op    = ExtU;
        ctrl.reg_wr    = 1'b1;
        ctrl.alu_b_ctr = AluBImm;
        ctrl.alu_ctr   = AluCopyB;
        use_rd         = 1'b1;
      end
      OpAuipc: begin
        ctrl.ext_op    = ExtU;
        ctrl.reg_wr    = 1'b1;
        ctrl.alu_a_ctr = 1'b1;
        ctrl.alu_b_ctr = AluBImm;
        use_rd         = 1'b1;
      end
      OpJal: begin
        ctrl.ext_op    = ExtJ;
        ctrl.reg_wr    = 1'b1;
        ctrl.branch    = BrJal;
        ctrl.alu_a_ctr = 1'b1;
        ctrl.alu_b_ctr = AluBFour;
        use_rd         = 1'b1;
      end
      OpJalr: begin
        ctrl.ext_op    = ExtI;
        ctrl.reg_wr    = 1'b1;
        ctrl.branch    = BrJalr;
        ctrl.alu_a_ctr = 1'b1;
        ctrl.alu_b_ctr = AluBFour;
        use_rd         = 1'b1;
        use_rs1        = 1'b1;
        illegal        = (funct3 != 3'b000);
      end
      OpBranch: begin
        ctrl.ext_op = ExtB;
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
        case (funct3)
          3'b000:  begin ctrl.branch = BrEq; ctrl.alu_ctr = AluSlt;  end
          3'b001:  begin ctrl.branch = BrNe; ctrl.alu_ctr = AluSlt;  end
          3'b100:  begin ctrl.branch = BrLt; ctrl.alu_ctr = AluSlt;  end
          3'b101:  begin ctrl.branch = BrGe; ctrl.alu_ctr = AluSlt;  end
          3'b110:  begin ctrl.branch = BrLt; ctrl.alu_ctr = AluSltu; end
          3'b111:  begin ctrl.branch = BrGe; ctrl.alu_ctr = AluSltu; end
          default: illegal = 1'b1;
        endcase
      end
      OpLoad: begin
        ctrl.ext_op     = ExtI;
        ctrl.reg_wr     = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.mem_op     = funct3;
        ctrl.mem_wen    = 1'b1;
        ctrl.alu_b_ctr  = AluBImm;
        use_rd          = 1'b1;
        use_rs1         = 1'b1;
        illegal = !((funct3 inside {MemB, MemH, MemW, MemBu, MemHu}) ||
                    (Is64 && (funct3 inside {MemD, MemWu})));
      end
      OpStore: begin
        ctrl.ext_op    = ExtS;
        ctrl.mem_wr    = 1'b1;
        ctrl.mem_op    = funct3;
        ctrl.mem_wen   = 1'b1;
        ctrl.alu_b_ctr = AluBImm;
        use_rs1        = 1'b1;
        use_rs2        = 1'b1;
        illegal = !((funct3 inside {MemB, MemH, MemW}) || (Is64 && (funct3 == MemD)));
      end
      OpImm: begin
        ctrl.ext_op    = ExtI;
        ctrl.reg_wr    = 1'b1;
        ctrl.alu_b_ctr = AluBImm;
        ctrl.alu_ctr   = alu_op_from_f3(funct3);
        use_rd         = 1'b1;
        use_rs1        = 1'b1;
        // shamt[5] (instr[25]) only exists on RV64.
        if (funct3 == 3'b001) begin
          illegal = (instr[31:26] != 6'b0) || (!Is64 && instr[25]);
        end else if (funct3 == 3'b101) begin
          if (instr[30]) ctrl.alu_ctr = AluSra;
          illegal = ({instr[31], instr[29:26]} != 5'b0) || (!Is64 && instr[25]);
        end
      end
      OpReg: begin
        ctrl.reg_wr  = 1'b1;
        ctrl.alu_ctr = alu_op_from_f3(funct3);
        use_rd       = 1'b1;
        use_rs1      = 1'b1;
        use_rs2      = 1'b1;
        if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          ctrl.alu_ctr = AluSub;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          ctrl.alu_ctr = AluSra;
        end else if (funct7 != 7'b0) begin
          illegal = 1'b1;
        end
      end
      OpMiscMem: begin
        if (ENABLE_CSR && funct3 == 3'b000) sys.is_fence = 1'b1;
        else                                illegal      = 1'b1;
      end
      OpSystem: begin
        if (funct3 == 3'b000) begin
          if (instr == InstrEcall)                    sys.is_ecall  = 1'b1;
          else if (instr == InstrEbreak)              sys.is_ebreak = 1'b1;
          else if (ENABLE_CSR && instr == InstrMret)  sys.is_mret   = 1'b1;
          else                                        illegal       = 1'b1;
        end else if (ENABLE_CSR && funct3 != 3'b100) begin
          sys.csr_op     = funct3;
          sys.csr_addr   = instr[31:20];
          ctrl.ext_op    = ExtI;
          ctrl.reg_wr    = 1'b1;
          ctrl.alu_b_ctr = AluBImm;
          ctrl.alu_ctr   = AluCopyB;
          use_rd         = 1'b1;
          use_rs1        = !funct3[2];
          zimm_sel       = funct3[2];
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase

    // Illegal entries must not cause any architectural side effect before EXU traps.
    if (illegal) begin
      ctrl.reg_wr   = 1'b0;
      ctrl.mem_wr   = 1'b0;
      ctrl.mem_wen  = 1'b0;
      ctrl.branch   = BrNone;
      sys.csr_op    = CsrNone;
      sys.is_ecall  = 1'b0;
      sys.is_ebreak = 1'b0;
      sys.is_mret   = 1'b0;
      sys.is_fence  = 1'b0;
      use_rd        = 1'b0;
      use_rs1       = 1'b0;
      use_rs2       = 1'b0;
      zimm_sel      = 1'b0;
    end
    sys.illegal = illegal;
  end

  always_comb begin
    case (ctrl.ext_op)
      ExtI:    imm32 = {{20{instr[31]}}, instr[31:20]};
      ExtS:    imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      ExtB:    imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      ExtU:    imm32 = {instr[31:12], 12'b0};
      ExtJ:    imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = 32'b0;
    endcase
  end

  assign imm = zimm_sel ? XLEN'(instr[19:15]) : XLEN'($signed(imm32));
  assign rd  = use_rd  ? instr[11:7]  : 5'b0;
  assign rs1 = use_rs1 ? instr[19:15] : 5'b0;
  assign rs2 = use_rs2 ? instr[24:20] : 5'b0;

endmodule

// File: rtl/idu_stage.sv
// Registered decode stage: decodes the incoming word and queues the result in a small FIFO
// with valid/ready on both sides, flush, and an ebreak halt that blocks further intake.
module idu_stage
  import idu_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned DEPTH      = 2,
  parameter bit          ENABLE_CSR = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output ctrl_t           out_ctrl,
  output sys_t            out_sys,
  output logic            halted
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] PtrMax = PtrW'(DEPTH - 1);

  ctrl_t           dec_ctrl;
  sys_t            dec_sys;
  logic [XLEN-1:0] dec_imm;
  logic [4:0]      dec_rs1;
  logic [4:0]      dec_rs2;
  logic [4:0]      dec_rd;

  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic            halted_q, halted_d;
  logic            push;
  logic            pop;

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [XLEN-1:0] imm_mem  [DEPTH];
  logic [4:0]      rs1_mem  [DEPTH];
  logic [4:0]      rs2_mem  [DEPTH];
  logic [4:0]      rd_mem   [DEPTH];
  ctrl_t           ctrl_mem [DEPTH];
  sys_t            sys_mem  [DEPTH];

  idu_decode_comb #(
    .XLEN       (XLEN),
    .ENABLE_CSR (ENABLE_CSR)
  ) u_decode (
    .instr (in_instr),
    .ctrl  (dec_ctrl),
    .sys   (dec_sys),
    .imm   (dec_imm),
    .rs1   (dec_rs1),
    .rs2   (dec_rs2),
    .rd    (dec_rd)
  );

  assign in_ready  = (count_q < CntW'(DEPTH)) && !halted_q;
  assign out_valid = (count_q != '0);
  assign halted    = halted_q;

  // Flush wins over both handshakes.
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    halted_d = halted_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      halted_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = (rd_ptr_q == PtrMax) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (push && dec_sys.is_ebreak) halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      halted_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      halted_q <= halted_d;
    end
  end

  // Payload storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= in_pc;
      imm_mem[wr_ptr_q]  <= dec_imm;
      rs1_mem[wr_ptr_q]  <= dec_rs1;
      rs2_mem[wr_ptr_q]  <= dec_rs2;
      rd_mem[wr_ptr_q]   <= dec_rd;
      ctrl_mem[wr_ptr_q] <= dec_ctrl;
      sys_mem[wr_ptr_q]  <= dec_sys;
    end
  end

  assign out_pc   = out_valid ? pc_mem[rd_ptr_q]   : '0;
  assign out_imm  = out_valid ? imm_mem[rd_ptr_q]  : '0;
  assign out_rs1  = out_valid ? rs1_mem[rd_ptr_q]  : '0;
  assign out_rs2  = out_valid ? rs2_mem[rd_ptr_q]  : '0;
  assign out_rd   = out_valid ? rd_mem[rd_ptr_q]   : '0;
  assign out_ctrl = out_valid ? ctrl_mem[rd_ptr_q] : '0;
  assign out_sys  = out_valid ? sys_mem[rd_ptr_q]  : '0;

endmodule

// File: tb/tb_idu_stage.sv
// Directed bench for idu_stage: two instances (CSR decode on/off) share all inputs.
module tb_idu_stage;
  import idu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_ready;

  logic        in_ready, out_valid, halted;
  logic [31:0] out_pc, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  ctrl_t       out_ctrl;
  sys_t        out_sys;

  logic        n_in_ready, n_out_valid, n_halted;
  logic [31:0] n_out_pc, n_out_imm;
  logic [4:0]  n_out_rs1, n_out_rs2, n_out_rd;
  ctrl_t       n_out_ctrl;
  sys_t        n_out_sys;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  idu_stage #(.XLEN(32), .DEPTH(2), .ENABLE_CSR(1'b1)) dut (
    .clk (clk), .rst (rst), .flush (flush),
    .in_valid (in_valid), .in_ready (in_ready), .in_instr (in_instr), .in_pc (in_pc),
    .out_valid (out_valid), .out_ready (out_ready), .out_pc (out_pc), .out_imm (out_imm),
    .out_rs1 (out_rs1), .out_rs2 (out_rs2), .out_rd (out_rd),
    .out_ctrl (out_ctrl), .out_sys (out_sys), .halted (halted)
  );

  idu_stage #(.XLEN(32), .DEPTH(2), .ENABLE_CSR(1'b0)) dut_nocsr (
    .clk (clk), .rst (rst), .flush (flush),
    .in_valid (in_valid), .in_ready (n_in_ready), .in_instr (in_instr), .in_pc (in_pc),
    .out_valid (n_out_valid), .out_ready (out_ready), .out_pc (n_out_pc),
    .out_imm (n_out_imm), .out_rs1 (n_out_rs1), .out_rs2 (n_out_rs2), .out_rd (n_out_rd),
    .out_ctrl (n_out_ctrl), .out_sys (n_out_sys), .halted (n_halted)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] instr, input logic [31:0] pc);
    in_instr = instr;
    in_pc    = pc;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_halted", halted, 0);
    check("rst_imm", out_imm, 0);
    step();
    rst = 1'b0;
    step();

    // addi x1,x0,5
    push_one(32'h0050_0093, 32'h100);
    check("addi_valid", out_valid, 1);
    check("addi_rd", out_rd, 1);
    check("addi_rs1", out_rs1, 0);
    check("addi_imm", out_imm, 5);
    check("addi_regwr", out_ctrl.reg_wr, 1);
    check("addi_extop", out_ctrl.ext_op, 0);
    check("addi_illegal", out_sys.illegal, 0);
    check("addi_pc", out_pc, 32'h100);

    // lui x2,0x12345 ; beq x1,x2,-4 ; back to back
    push_one(32'h1234_5137, 32'h104);
    check("lui_imm", out_imm, 32'h1234_5000);
    check("lui_rd", out_rd, 2);
    check("lui_extop", out_ctrl.ext_op, 1);
    push_one(32'hFE20_8EE3, 32'h108);
    check("beq_imm", out_imm, 32'hFFFF_FFFC);
    check("beq_regwr", out_ctrl.reg_wr, 0);
    check("beq_rd", out_rd, 0);
    check("beq_rs1", out_rs1, 1);
    check("beq_rs2", out_rs2, 2);
    check("beq_branch", out_ctrl.branch, 3'b100);
    check("beq_extop", out_ctrl.ext_op, 3);
    step();
    check("drain_empty", out_valid, 0);

    // Backpressure with DEPTH=2
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h0050_0093;
    step();
    check("bp_ready_1", in_ready, 1);
    in_instr = 32'h0060_0113;
    step();
    check("bp_ready_full", in_ready, 0);
    in_instr = 32'h0070_0193;
    step();
    check("bp_held_ready", in_ready, 0);
    check("bp_head_stable", out_imm, 5);
    out_ready = 1'b1;
    step();
    check("bp_pop1_ready", in_ready, 1);
    check("bp_pop1_imm", out_imm, 6);
    step();
    in_valid = 1'b0;
    check("bp_third_imm", out_imm, 7);
    check("bp_third_rd", out_rd, 3);
    check("bp_third_valid", out_valid, 1);
    step();
    check("bp_empty", out_valid, 0);

    // ebreak halt, refusal, drain, flush
    push_one(32'h0010_0073, 32'h200);
    check("ebk_flag", out_sys.is_ebreak, 1);
    check("ebk_halted", halted, 1);
    check("ebk_in_ready", in_ready, 0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h0050_0093;
    step();
    check("ebk_refuse_head", out_sys.is_ebreak, 1);
    out_ready = 1'b1;
    step();
    check("ebk_drained", out_valid, 0);
    check("ebk_still_halted", halted, 1);
    in_valid = 1'b0;
    flush    = 1'b1;
    step();
    flush = 1'b0;
    check("flush_halted", halted, 0);
    check("flush_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);

    // CSR on/off, zero word, misc formats
    push_one(32'h3000_1073, 32'h300);
    check("csr_on_illegal", out_sys.illegal, 0);
    check("csr_on_addr", out_sys.csr_addr, 12'h300);
    check("csr_on_op", out_sys.csr_op, 3'b001);
    check("csr_off_illegal", n_out_sys.illegal, 1);
    check("csr_off_regwr", n_out_ctrl.reg_wr, 0);
    push_one(32'h0000_0000, 32'h304);
    check("zero_on_illegal", out_sys.illegal, 1);
    check("zero_off_illegal", n_out_sys.illegal, 1);
    check("zero_regwr", out_ctrl.reg_wr, 0);
    push_one(32'h4010_5093, 32'h308);
    check("srai_illegal", out_sys.illegal, 0);
    check("srai_aluctr", out_ctrl.alu_ctr, 4'hD);
    push_one(32'h0200_1093, 32'h30C);
    check("slli_sh5_illegal", out_sys.illegal, 1);
    push_one(32'h0080_A283, 32'h310);
    check("lw_memwen", out_ctrl.mem_wen, 1);
    check("lw_memtoreg", out_ctrl.mem_to_reg, 1);
    check("lw_memop", out_ctrl.mem_op, 2);
    check("lw_rd", out_rd, 5);
    push_one(32'hFE20_AE23, 32'h314);
    check("sw_imm", out_imm, 32'hFFFF_FFFC);
    check("sw_memwr", out_ctrl.mem_wr, 1);
    check("sw_extop", out_ctrl.ext_op, 2);
    check("sw_rd", out_rd, 0);
    push_one(32'h0080_00EF, 32'h318);
    check("jal_imm", out_imm, 8);
    check("jal_branch", out_ctrl.branch, 3'b001);
    check("jal_extop", out_ctrl.ext_op, 4);
    step();

    // Flush with simultaneous push drops everything
    out_ready = 1'b0;
    push_one(32'h0050_0093, 32'h400);
    push_one(32'h0060_0113, 32'h404);
    check("pre_flush_full", in_ready, 0);
    in_valid = 1'b1;
    in_instr = 32'h1234_5137;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flushpush_valid", out_valid, 0);
    check("flushpush_ready", in_ready, 1);
    step();
    check("flushpush_dropped", out_valid, 0);

    // Async reset mid-traffic, including a pending halt
    push_one(32'h0010_0073, 32'h500);
    in_valid = 1'b1;
    in_instr = 32'h0050_0093;
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_imm", out_imm, 0);
    check("arst_halted", halted, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_ctrl", out_ctrl, 0);
    in_valid = 1'b0;
    #1;
    rst = 1'b0;
    step();
    check("post_rst_valid", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
